// File: rtl/riscv_ram_hs.sv
// rtl/riscv_ram_hs.sv - handshaked single-port data RAM with byte strobes, registered read response and post-reset clear
module riscv_ram_hs #(
  parameter int DATA_WIDTH = 64,
  parameter int DATA_DEPTH = 4096,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DATA_DEPTH - 1);
  // When the depth fills the address space every address is legal.
  localparam bit                    FULL_RANGE = ((1 << ADDR_WIDTH) == DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  state_t                state;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic                  init_done_d;
  logic                  clr_we;

  logic                  in_range;
  logic                  accept;
  logic                  wr_accept;
  logic                  rd_accept;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [STRB_WIDTH-1:0] mem_strb;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign in_range  = FULL_RANGE || (32'(req_addr) < 32'(DATA_DEPTH));
  assign accept    = req_valid && req_ready;
  assign wr_accept = accept && req_we && in_range;
  assign rd_accept = accept && !req_we;

  // Control state, clear counter and init flag; all reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      init_done <= init_done_d;
    end
  end

  // Next-state logic: clear sweep in INIT, handshake gating in READY.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    init_done_d = init_done;
    clr_we      = 1'b0;
    req_ready   = 1'b0;
    case (state)
      ST_INIT: begin
        if (INIT_ZERO) begin
          clr_we = 1'b1;
          cnt_d  = cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state_d     = ST_READY;
            init_done_d = 1'b1;
          end
        end else begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      ST_READY: begin
        // A held response blocks new requests unless it drains this edge.
        req_ready = init_done && (!rsp_valid || rsp_ready);
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Single write port shared by the clear engine and accepted writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = req_addr;
    mem_strb  = req_wstrb;
    mem_wdata = req_wdata;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = cnt;
      mem_strb  = '1;
      mem_wdata = '0;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
  end

  // Storage array, no reset; byte lanes written only where strobed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (mem_strb[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read response; out-of-range reads answer with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (rd_accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= in_range ? mem[req_addr] : '0;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
